// File: rtl/fsub_pipe.sv
// Purpose: pipelined floating-point subtractor, result = a - b (truncating, no rounding).
// Latency: 3 cycles (swap/align, add/sub, normalize); throughput 1 per cycle.
// Backpressure: global stall; every stage holds while out_valid & ~out_ready.
module fsub_pipe #(
    parameter int BIT_W = 32,
    parameter int EXP_W = 8,
    parameter int M_W   = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIT_W-1:0] a,
    input  logic [BIT_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIT_W-1:0] result,
    output logic             flag_exc,
    output logic             flag_zero
);
    // Mantissa field: hidden bit + stored mantissa + 2 guard bits; sum adds a carry bit.
    localparam int MF_W  = M_W + 3;
    localparam int SUM_W = M_W + 4;
    localparam int LZ_W  = $clog2(MF_W + 1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic enable;

    // Stage 1 registers
    logic             s1_vld_q;
    logic             s1_sx_q, s1_sy_q, s1_exc_q;
    logic [EXP_W-1:0] s1_ex_q;
    logic [MF_W-1:0]  s1_mx_q, s1_my_q;
    // Stage 2 registers
    logic             s2_vld_q;
    logic             s2_sign_q, s2_exc_q;
    logic [EXP_W-1:0] s2_ex_q;
    logic [SUM_W-1:0] s2_sum_q;
    // Output registers
    logic             out_vld_q;
    logic [BIT_W-1:0] result_q;
    logic             exc_q, zero_q;

    assign enable    = ~out_vld_q | out_ready;
    assign in_ready  = enable & ~rst;
    assign out_valid = out_vld_q;
    assign result    = result_q;
    assign flag_exc  = exc_q;
    assign flag_zero = zero_q;

    // Stage 1 next state: invert b's sign, order by magnitude, align the smaller operand.
    logic [BIT_W-1:0] bn_d, x_d, y_d;
    logic [EXP_W-1:0] ex_d, ey_d, ediff_d;
    logic [MF_W-1:0]  mx_d, my_d, my_sh_d;
    logic             exc_d;
    always_comb begin
        bn_d = {~b[BIT_W-1], b[BIT_W-2:0]};
        if (a[BIT_W-2:0] >= bn_d[BIT_W-2:0]) begin
            x_d = a;
            y_d = bn_d;
        end else begin
            x_d = bn_d;
            y_d = a;
        end
        ex_d    = x_d[BIT_W-2:M_W];
        ey_d    = y_d[BIT_W-2:M_W];
        // A zero exponent means exact zero: no hidden bit, mantissa bits ignored.
        mx_d    = (ex_d == '0) ? '0 : {1'b1, x_d[M_W-1:0], 2'b00};
        my_d    = (ey_d == '0) ? '0 : {1'b1, y_d[M_W-1:0], 2'b00};
        ediff_d = ex_d - ey_d;
        my_sh_d = (int'(ediff_d) >= MF_W) ? '0 : (my_d >> ediff_d);
        exc_d   = (a[BIT_W-2:M_W] == EXP_MAX) | (b[BIT_W-2:M_W] == EXP_MAX);
    end

    // Stage 1 register: capture aligned operands when the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_sx_q  <= 1'b0;
            s1_sy_q  <= 1'b0;
            s1_exc_q <= 1'b0;
            s1_ex_q  <= '0;
            s1_mx_q  <= '0;
            s1_my_q  <= '0;
        end else if (enable) begin
            s1_vld_q <= in_valid;
            s1_sx_q  <= x_d[BIT_W-1];
            s1_sy_q  <= y_d[BIT_W-1];
            s1_exc_q <= exc_d;
            s1_ex_q  <= ex_d;
            s1_mx_q  <= mx_d;
            s1_my_q  <= my_sh_d;
        end
    end

    // Stage 2 next state: magnitude add or subtract; X >= Y so the difference never goes negative.
    logic [SUM_W-1:0] s2_sum_d;
    always_comb begin
        if (s1_sx_q ^ s1_sy_q) begin
            s2_sum_d = {1'b0, s1_mx_q} - {1'b0, s1_my_q};
        end else begin
            s2_sum_d = {1'b0, s1_mx_q} + {1'b0, s1_my_q};
        end
    end

    // Stage 2 register: sum, result sign and the larger operand's exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_exc_q  <= 1'b0;
            s2_ex_q   <= '0;
            s2_sum_q  <= '0;
        end else if (enable) begin
            s2_vld_q  <= s1_vld_q;
            s2_sign_q <= s1_sx_q;
            s2_exc_q  <= s1_exc_q;
            s2_ex_q   <= s1_ex_q;
            s2_sum_q  <= s2_sum_d;
        end
    end

    // Stage 3 next state: normalize (carry shift or leading-zero shift) and resolve zero/exception.
    logic             carry_d;
    logic [MF_W-1:0]  field_d, norm_d;
    logic [LZ_W-1:0]  lz_d;
    logic [EXP_W:0]   exp_n_d;
    logic [BIT_W-1:0] result_d;
    logic             exc_out_d, zero_out_d;
    always_comb begin
        carry_d = s2_sum_q[SUM_W-1];
        field_d = carry_d ? s2_sum_q[SUM_W-1:1] : s2_sum_q[MF_W-1:0];
        lz_d    = LZ_W'(MF_W);
        for (int i = 0; i < MF_W; i++) begin
            if (field_d[i]) lz_d = LZ_W'(MF_W - 1 - i);
        end
        norm_d  = field_d << lz_d;
        // One extra exponent bit: the MSB flags a negative (underflowed) exponent.
        if (carry_d) begin
            exp_n_d = {1'b0, s2_ex_q} + (EXP_W+1)'(1);
        end else begin
            exp_n_d = {1'b0, s2_ex_q} - (EXP_W+1)'(lz_d);
        end
        result_d   = '0;
        exc_out_d  = 1'b0;
        zero_out_d = 1'b0;
        if (s2_exc_q) begin
            exc_out_d = 1'b1;
        end else if (s2_sum_q == '0) begin
            zero_out_d = 1'b1;
        end else if (exp_n_d[EXP_W] || exp_n_d == '0) begin
            zero_out_d = 1'b1;
        end else if (exp_n_d[EXP_W-1:0] == EXP_MAX) begin
            exc_out_d = 1'b1;
        end else begin
            result_d = {s2_sign_q, exp_n_d[EXP_W-1:0], norm_d[MF_W-2:2]};
        end
    end

    // Output register: loaded only with valid results so the held word stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (enable) begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                result_q <= result_d;
                exc_q    <= exc_out_d;
                zero_q   <= zero_out_d;
            end
        end
    end
endmodule
